// File: rtl/approx_err_pkg.sv
// Shared constants, FSM encoding and S1 payload for the approximate-adder
// error accumulator.
package approx_err_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 32;
  localparam int ACC_W_DEF = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Sized by the default widths; the top is built with WIDTH/CNT_W at defaults.
  typedef struct packed {
    logic [WIDTH_DEF:0]   ed;
    logic                 nz;
    logic [CNT_W_DEF-1:0] idx;
  } s1_payload_t;

endpackage

// File: rtl/approx_err_accum_err_dist_calc.sv
// Exact sum of the operands and absolute distance to the approximate sum.
module err_dist_calc
  import approx_err_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH:0]   approx_sum,
  output logic [WIDTH:0]   ed
);

  logic [WIDTH:0]          exact;
  logic signed [WIDTH+1:0] diff;

  assign exact = {1'b0, op_a} + {1'b0, op_b};
  assign diff  = $signed({1'b0, exact}) - $signed({1'b0, approx_sum});
  // The magnitude always fits in WIDTH+1 bits, so negate only the low bits.
  assign ed    = diff[WIDTH+1] ? (~diff[WIDTH:0] + 1'b1) : diff[WIDTH:0];

endmodule

// File: rtl/approx_err_accum.sv
// Run-statistics accumulator for approximate adders: error count, saturating
// sum of error distance, worst-case distance and first failing sample index.
module approx_err_accum
  import approx_err_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH:0]   approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_ed,
  output logic [WIDTH:0]   max_ed,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             sat
);

  state_t           state;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] accepted;
  logic             accept;
  logic             last_accept;
  logic [WIDTH:0]   ed_p0;
  logic             vld_p1;
  s1_payload_t      s1_p1;
  logic [ACC_W:0]   sum_raw;

  function automatic logic [ACC_W-1:0] sat_clamp(input logic [ACC_W:0] x);
    return x[ACC_W] ? {ACC_W{1'b1}} : x[ACC_W-1:0];
  endfunction

  assign in_ready    = (state == RUN) && (accepted < target);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && ((accepted + 1'b1) == target);
  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);
  assign sum_raw     = {1'b0, sum_ed} + {{(ACC_W-WIDTH){1'b0}}, s1_p1.ed};

  err_dist_calc #(.WIDTH(WIDTH)) u_calc (
    .op_a       (op_a),
    .op_b       (op_b),
    .approx_sum (approx_sum),
    .ed         (ed_p0)
  );

  // S1: payload register, loaded only on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_p1.ed  <= ed_p0;
      s1_p1.nz  <= |ed_p0;
      s1_p1.idx <= accepted;
    end
  end

  // S2: control, counters and result accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      target        <= '0;
      accepted      <= '0;
      vld_p1        <= 1'b0;
      err_count     <= '0;
      sum_ed        <= '0;
      max_ed        <= '0;
      first_err_idx <= '1;
      sat           <= 1'b0;
    end else begin
      vld_p1 <= accept;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            target        <= num_samples;
            accepted      <= '0;
            err_count     <= '0;
            sum_ed        <= '0;
            max_ed        <= '0;
            first_err_idx <= '1;
            sat           <= 1'b0;
            state         <= (num_samples == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (accept) accepted <= accepted + 1'b1;
          if (last_accept) state <= DRAIN;
        end
        // DRAIN holds only the last sample in S1; it retires on this edge.
        DRAIN: state <= DONE;
        default: state <= IDLE;
      endcase

      if (vld_p1) begin
        err_count <= err_count + {{(CNT_W-1){1'b0}}, s1_p1.nz};
        sum_ed    <= sat_clamp(sum_raw);
        if (sum_raw[ACC_W]) sat <= 1'b1;
        if (s1_p1.ed > max_ed) max_ed <= s1_p1.ed;
        if (s1_p1.nz && (first_err_idx == '1)) first_err_idx <= s1_p1.idx;
      end
    end
  end

endmodule
